alu_issue: RTL and testbench

Decode-and-issue stage that drives the ALU. Accepts one RV32I instruction per cycle, with its PC and register-file operand values, over a valid/ready handshake. Decodes OP, OP-IMM, LUI and AUIPC into an `rvcpu::alu_op_t` plus the selected A/B operands, and presents a registered, back-pressurable result to the execute stage. Sits between the register-read stage and the ALU.

---
 rtl/alu_issue.sv | 181 ++++++++++++++++++
 tb/tb_alu_issue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// RV32I decode-and-issue stage feeding the ALU: decodes OP/OP-IMM/LUI/AUIPC into
// an ALU op plus A/B operands behind a valid/ready register. RVCPU_ISSUE_SKID_EN adds a skid entry.
package rvcpu;
  // alu_add is encoding 0 so an all-zero packet is the reset packet.
  typedef enum logic [3:0] {
    alu_add = 4'd0, alu_sub, alu_sll, alu_slt, alu_xor, alu_srl, alu_sra, alu_or, alu_and
  } alu_op_t;
endpackage

module alu_issue #(
  parameter int Width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [Width-1:0]     in_pc,
  input  logic [Width-1:0]     in_rs1_val,
  input  logic [Width-1:0]     in_rs2_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output rvcpu::alu_op_t       out_op,
  output logic [Width-1:0]     out_a,
  output logic [Width-1:0]     out_b,
  output logic                 out_cmp_unsigned,
  output logic [4:0]           out_rd,
  output logic                 out_rd_we,
  output logic                 out_illegal
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    rvcpu::alu_op_t   op;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic             cmp_u;
    logic [4:0]       rd;
    logic             rd_we;
    logic             illegal;
  } pkt_t;

  function automatic rvcpu::alu_op_t f3_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return rvcpu::alu_add;
      3'd1:    return rvcpu::alu_sll;
      3'd2,
      3'd3:    return rvcpu::alu_slt;
      3'd4:    return rvcpu::alu_xor;
      3'd5:    return rvcpu::alu_srl;
      3'd6:    return rvcpu::alu_or;
      default: return rvcpu::alu_and;
    endcase
  endfunction

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       ill;
  pkt_t       dec;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  always_comb begin
    dec   = '0;
    ill   = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.a     = in_rs1_val;
        dec.b     = in_rs2_val;
        dec.op    = f3_op(f3);
        dec.cmp_u = (f3 == 3'd3);
        if (f7 == F7_ALT) begin
          if (f3 == 3'd0)      dec.op = rvcpu::alu_sub;
          else if (f3 == 3'd5) dec.op = rvcpu::alu_sra;
          else                 ill    = 1'b1;
        end else if (f7 != 7'd0) begin
          ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.a     = in_rs1_val;
        dec.b     = Width'($signed(in_instr[31:20]));
        dec.op    = f3_op(f3);
        dec.cmp_u = (f3 == 3'd3);
        // Shift immediates carry funct7 in the upper bits; only shamt is the operand.
        if (f3 == 3'd1) begin
          dec.b = Width'(in_instr[24:20]);
          ill   = (f7 != 7'd0);
        end else if (f3 == 3'd5) begin
          dec.b = Width'(in_instr[24:20]);
          if (f7 == F7_ALT)      dec.op = rvcpu::alu_sra;
          else if (f7 != 7'd0)   ill    = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.b = Width'($signed({in_instr[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        dec.a = in_pc;
        dec.b = Width'($signed({in_instr[31:12], 12'b0}));
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.op    = rvcpu::alu_add;
      dec.a     = '0;
      dec.b     = '0;
      dec.cmp_u = 1'b0;
    end
    dec.illegal = ill;
    dec.rd      = in_instr[11:7];
    dec.rd_we   = (in_instr[11:7] != 5'd0) && !ill;
  end

  pkt_t main_q;
  logic main_v;

`ifdef RVCPU_ISSUE_SKID_EN
  pkt_t skid_q;
  logic skid_v, rdy_q;

  // Skid only fills when main is stalled; it always drains ahead of new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      main_v <= 1'b0;
      skid_q <= '0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (skid_v) begin
      if (out_ready) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
        rdy_q  <= 1'b1;
      end
    end else if (in_valid && rdy_q) begin
      if (!main_v || out_ready) begin
        main_q <= dec;
        main_v <= 1'b1;
      end else begin
        skid_q <= dec;
        skid_v <= 1'b1;
        rdy_q  <= 1'b0;
      end
    end else if (out_ready) begin
      main_v <= 1'b0;
    end
  end

  assign in_ready = rdy_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      main_v <= 1'b0;
    end else if (in_valid && in_ready) begin
      main_q <= dec;
      main_v <= 1'b1;
    end else if (out_ready) begin
      main_v <= 1'b0;
    end
  end

  assign in_ready = !main_v || out_ready;
`endif

  assign out_valid        = main_v;
  assign out_op           = main_q.op;
  assign out_a            = main_q.a;
  assign out_b            = main_q.b;
  assign out_cmp_unsigned = main_q.cmp_u;
  assign out_rd           = main_q.rd;
  assign out_rd_we        = main_q.rd_we;
  assign out_illegal      = main_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected packets are queued on accept and
// compared by an independent monitor whenever out_valid is high.
module tb_alu_issue;
  import rvcpu::*;

`ifdef RVCPU_ISSUE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1_val = '0, in_rs2_val = '0;
  alu_op_t     out_op;
  logic [31:0] out_a, out_b;
  logic        out_cmp_unsigned, out_rd_we, out_illegal;
  logic [4:0]  out_rd;

  alu_issue #(.Width(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_a(out_a),
    .out_b(out_b), .out_cmp_unsigned(out_cmp_unsigned), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_op_t     op;
    logic [31:0] a, b;
    logic        cu, we, ill;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   rmode = 2;

  function automatic alu_op_t base_op(input int f3);
    case (f3)
      0: return alu_add;   1: return alu_sll;   2: return alu_slt;   3: return alu_slt;
      4: return alu_xor;   5: return alu_srl;   6: return alu_or;    default: return alu_and;
    endcase
  endfunction

  // Reference decode straight from the ISA field rules.
  function automatic exp_t model(input logic [31:0] ins, pc, r1, r2);
    exp_t e;
    int   f3  = int'(ins[14:12]);
    int   f7  = int'(ins[31:25]);
    int   opc = int'(ins[6:0]);
    bit   ill = 1'b0;
    e.op = alu_add; e.a = 0; e.b = 0; e.cu = 0;
    e.rd = ins[11:7];
    if (opc == 'h33) begin
      ill  = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
      e.op = (f7 == 'h20) ? ((f3 == 0) ? alu_sub : alu_sra) : base_op(f3);
      e.a  = r1; e.b = r2; e.cu = (f3 == 3);
    end else if (opc == 'h13) begin
      ill  = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20);
      e.op = (f3 == 5 && f7 == 'h20) ? alu_sra : base_op(f3);
      e.a  = r1; e.cu = (f3 == 3);
      e.b  = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : 32'(int'($signed(ins[31:20])));
    end else if (opc == 'h37) begin
      e.b = ins & 32'hFFFF_F000;
    end else if (opc == 'h17) begin
      e.a = pc; e.b = ins & 32'hFFFF_F000;
    end else begin
      ill = 1'b1;
    end
    if (ill) begin e.op = alu_add; e.a = 0; e.b = 0; e.cu = 0; end
    e.ill = ill;
    e.we  = !ill && (e.rd != 0);
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    int s = $urandom_range(0, 3);
    logic [6:0] f7 = (s == 0) ? 7'h20 : (s == 1) ? 7'(w[31:25]) : 7'h00;
    if (k <= 2)      w = {f7, w[24:7], 7'h33};
    else if (k <= 5) w = (w[13:12] == 2'b01) ? {f7, w[24:7], 7'h13} : {w[31:7], 7'h13};
    else if (k == 6) w = {w[31:7], 7'h37};
    else if (k == 7) w = {w[31:7], 7'h17};
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard push on every accepted input.
  always @(negedge clk)
    if (rst_n && in_valid && in_ready)
      q.push_back(model(in_instr, in_pc, in_rs1_val, in_rs2_val));

  // Monitor: a presented packet must match the queue head; pop on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_packet op=%0d a=%h b=%h rd=%0d", out_op, out_a, out_b, out_rd);
      end else begin
        if (out_op !== q[0].op || out_a !== q[0].a || out_b !== q[0].b ||
            out_cmp_unsigned !== q[0].cu || out_rd !== q[0].rd ||
            out_rd_we !== q[0].we || out_illegal !== q[0].ill) begin
          errors++;
          $display("FAIL packet actual op=%0d a=%h b=%h cu=%b rd=%0d we=%b ill=%b expected op=%0d a=%h b=%h cu=%b rd=%0d we=%b ill=%b",
                   out_op, out_a, out_b, out_cmp_unsigned, out_rd, out_rd_we, out_illegal,
                   q[0].op, q[0].a, q[0].b, q[0].cu, q[0].rd, q[0].we, q[0].ill);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (rmode == 0)      out_ready = 1'b1;
    else if (rmode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic drive(input logic [31:0] ins, pc, r1, r2);
    bit fire;
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1_val = r1; in_rs2_val = r2;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk); fire = in_ready;
      @(posedge clk); #1;
      if (fire) break;
      if (k == 63) begin
        checks++; errors++;
        $display("FAIL accept_timeout instr=%h", ins);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_op", 32'(out_op), 32'(alu_add));
    chk("rst_fields", {out_a | out_b}, 32'd0);
    chk("rst_flags", {24'd0, out_rd, out_cmp_unsigned, out_rd_we, out_illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed decode cases.
    rmode = 0; out_ready = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_op", 32'(out_op), 32'(alu_add));
    chk("add_ab", {out_a[15:0], out_b[15:0]}, {16'd5, 16'd7});
    chk("add_rd", {26'd0, out_rd, out_rd_we}, {26'd0, 5'd3, 1'b1});
    drive(32'h40435293, 32'h0, 32'h8000_0000, 32'h0);
    chk("srai_op", 32'(out_op), 32'(alu_sra));
    chk("srai_b", out_b, 32'd4);
    chk("srai_a", out_a, 32'h8000_0000);
    drive(32'h123450B7, 32'h0, 32'h1111, 32'h2222);
    chk("lui_b", out_b, 32'h1234_5000);
    chk("lui_a", out_a, 32'd0);
    drive(32'h12345097, 32'h100, 32'h1111, 32'h2222);
    chk("auipc_a", out_a, 32'h100);
    drive(32'hFFFF_FFFF, 32'h4, 32'h33, 32'h44);
    chk("ill_ones", {29'd0, out_illegal, out_rd_we, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
    drive(32'h4020C1B3, 32'h8, 32'h55, 32'h66);
    chk("ill_subxor", {29'd0, out_illegal, out_rd_we, 1'b0}, 32'd4);
    chk("ill_ab", out_a | out_b, 32'd0);
    drive(32'h00508013, 32'hC, 32'h9, 32'h0);
    chk("addi_x0", {30'd0, out_illegal, out_rd_we}, 32'd0);

    // Eight ADDIs with a three-cycle output stall mid-stream.
    rmode = 2; out_ready = 1'b1;
    fork
      for (int i = 1; i <= 8; i++)
        drive({12'(i), 5'd1, 3'd0, 5'(i), 7'h13}, 32'(i * 4), 32'(i * 100), 32'h0);
      begin
        repeat (3) @(posedge clk); #1; out_ready = 1'b0;
        repeat (3) @(posedge clk); #1; out_ready = 1'b1;
      end
    join
    idle(4);
    chk("stream_drained", 32'(q.size()), 32'd0);

    // Stall behaviour of in_ready after accepts into a stalled stage.
    out_ready = 1'b0;
    drive(32'h00108093, 32'h0, 32'h1, 32'h0);
    chk("ready_after_1st_stall", 32'(in_ready), 32'(SKID));
    if (SKID) begin
      drive(32'h00208113, 32'h0, 32'h2, 32'h0);
      chk("ready_after_2nd_stall", 32'(in_ready), 32'd0);
    end
    idle(2);
    out_ready = 1'b1;
    idle(4);

    // Randomized traffic with random back-pressure.
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      drive(rnd_instr(), $urandom, $urandom, $urandom);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    rmode = 0;
    idle(6);
    chk("random_drained", 32'(q.size()), 32'd0);

    // Asynchronous reset while a packet is held under stall.
    rmode = 2; out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_a", out_a, 32'd0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk("postrst_issue", {31'd0, out_valid}, 32'd1);
    chk("postrst_a", out_a, 32'd5);

    for (int k = 0; k < 50 && q.size() > 0; k++) idle(1);
    idle(2);
    chk("final_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
